flappy_bird_physics: RTL and testbench
======================================

# flappy_bird_physics

Parametrised vertical-physics engine for the bird sprite, replacing the fixed-step flap/gravity FSM. Holds the bird's X/Y screen position and a signed vertical velocity. Applies flap impulses and saturating gravity on each physics tick, and detects floor, ceiling and pipe-collision loss. Sits between the button/timing logic (tick enable, Flap_Button) and the VGA renderer and pipe/collision block (XBird, YBird, Hit).

## Interface
- COORD_W, 10: width of XBird/YBird
- VEL_W, 5: width of signed velocity
- X_START, 144: fixed X position
- Y_START, 240: Y position at reset and in I
- Y_CEIL, 0: topmost legal Y
- Y_FLOOR, 464: Y at which the bird lands and loses
- FLAP_VEL, 6: upward speed (pixels/tick) during a flap
- FLAP_TICKS, 4: length of a flap, in ticks
- GRAV, 1: velocity increment per tick
- VMAX, 8: maximum downward velocity
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- SCEN  in  1  physics tick enable; all non-reset updates occur only when SCEN=1
- Start  in  1  leave I and begin with a flap
- Ack  in  1  leave LOST and return to I
- Flap_Button  in  1  level of flap button (already debounced)
- Hit  in  1  pipe collision from the collision block
- XBird  out  COORD_W  bird X (constant X_START)
- YBird  out  COORD_W  bird Y; screen Y grows downward
- VelBird  out  VEL_W  signed velocity; negative means upward
- q_I, q_Flap, q_UnPress, q_Grav, q_Lost  out  1 each  one-hot state

## Operation
- States: I, FLAP, UNPRESS, GRAV, LOST; one-hot encoding.
- Reset: state=I, YBird=Y_START, XBird=X_START, VelBird=0, flap counter=0. Reset overrides everything, including when it arrives mid-flap or in LOST.
- I: Y, velocity and counter are held at their reset values. Start → FLAP; on that tick velocity is set to −FLAP_VEL and Y is unchanged.
- FLAP: each tick, Y += vel with velocity held at −FLAP_VEL and counter++. On the FLAP_TICKS-th tick, go to UNPRESS and clear the counter.
- UNPRESS: gravity applies. !Flap_Button → GRAV. Holding the button never re-flaps.
- GRAV: gravity applies. Flap_Button → FLAP; that tick sets vel=−FLAP_VEL and Y += old vel. The counter restarts.
- Gravity tick: Y_next = Y + vel (old velocity), then vel_next = min(vel + GRAV, VMAX).
- Arithmetic: Y_next is computed in signed COORD_W+2 bits before any clamping, so it cannot wrap. Velocity saturates at VMAX and never wraps.
- Floor: Y_next ≥ Y_FLOOR → YBird=Y_FLOOR, vel=0, state → LOST.
- Ceiling: Y_next < Y_CEIL → YBird=Y_CEIL, vel=0. The state stays as it is, unless the ceiling macro below is defined.
- Hit=1 on a tick in FLAP/UNPRESS/GRAV → LOST. Position and velocity are still updated (and clamped) that tick, then frozen.
- Simultaneous events:
  - Hit and floor on the same tick → LOST with Y=Y_FLOOR.
  - Flap_Button and floor on the same tick in GRAV → LOST wins.
- LOST: Y and velocity frozen. Ack → I, and I reloads Y_START on the next tick. Ack outside LOST is ignored. Hit in I or LOST is ignored.

## Timing
- All outputs are registered.
- Each change is visible one Clk edge after the SCEN=1 cycle that caused it.
- With SCEN=0, no state, position or velocity change occurs.
- Start, Ack, Flap_Button and Hit are sampled only on SCEN=1 cycles. They must be held until a tick.
- Flap-to-fall latency: exactly FLAP_TICKS ticks from FLAP entry to UNPRESS.

## Configuration
- FLAPPY_CEIL_KILL_EN
  - Defined: reaching the ceiling (Y_next < Y_CEIL) clamps Y to Y_CEIL and enters LOST, with the same priority as the floor.
  - Undefined: the ceiling only clamps and zeroes the velocity; play continues.

## Structure
- Shared package flappy_pkg:
  - state localparams (I, FLAP, UNPRESS, GRAV, LOST)
  - default screen constants: X_START, Y_START, Y_CEIL, Y_FLOOR
  - used by both the renderer and the collision block
- One sub-module, flappy_vel_integrator, which is combinational plus its registers. It owns:
  - the velocity register
  - the saturating gravity add
  - the wide Y_next computation and floor/ceiling compare flags
- The top level keeps the FSM and the flap counter.

## Test plan
- Reset, then hold 3 ticks with no inputs → q_I=1, XBird=144, YBird=240, VelBird=0 throughout.
- Start on a tick, button released → VelBird=−6 and YBird=240. Next 4 ticks give YBird 234, 228, 222, 216, then q_UnPress=1, then q_Grav=1.
- From GRAV at Y=216, vel=−6, with button idle: Y sequence 210, 205, 201, 198, 196, …; velocity reaches +8 and stays at 8.
- Fall with vel=8 from Y=460 → next tick YBird=464, q_Lost=1. Ack → q_I=1; the next tick gives YBird=240.
- Flap held from Y=10 → Y clamps at 0 and vel=0.
  - Macro undefined: still q_Flap, play continues.
  - FLAPPY_CEIL_KILL_EN defined: q_Lost=1.
- Hit asserted mid-FLAP together with SCEN=0 → no change; on the next SCEN=1 → q_Lost with the updated Y. Reset asserted in LOST → q_I, Y=240 on the next edge.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared constants for the bird physics, renderer and collision blocks.
package flappy_pkg;

  localparam int unsigned COORD_W_DEF = 10;
  localparam int unsigned VEL_W_DEF   = 5;
  localparam int unsigned X_START_DEF = 144;
  localparam int unsigned Y_START_DEF = 240;
  localparam int unsigned Y_CEIL_DEF  = 0;
  localparam int unsigned Y_FLOOR_DEF = 464;

  // One-hot state bit positions and codes
  localparam int unsigned S_I       = 0;
  localparam int unsigned S_FLAP    = 1;
  localparam int unsigned S_UNPRESS = 2;
  localparam int unsigned S_GRAV    = 3;
  localparam int unsigned S_LOST    = 4;

  localparam logic [4:0] ST_I       = 5'b00001;
  localparam logic [4:0] ST_FLAP    = 5'b00010;
  localparam logic [4:0] ST_UNPRESS = 5'b00100;
  localparam logic [4:0] ST_GRAV    = 5'b01000;
  localparam logic [4:0] ST_LOST    = 5'b10000;

  // Per-tick operation requested from the integrator
  typedef enum logic [2:0] {
    OP_HOLD,
    OP_INIT,
    OP_LAUNCH,
    OP_FLAP,
    OP_GRAV
  } phys_op_e;

endpackage

// File: rtl/flappy_bird_physics_if.sv
// Control inputs and sprite/state outputs of the bird physics engine.
interface flappy_bird_physics_if
  import flappy_pkg::*;
#(
  parameter int unsigned COORD_W = COORD_W_DEF,
  parameter int unsigned VEL_W   = VEL_W_DEF
);
  logic                      SCEN;
  logic                      Start;
  logic                      Ack;
  logic                      Flap_Button;
  logic                      Hit;
  logic [COORD_W-1:0]        XBird;
  logic [COORD_W-1:0]        YBird;
  logic signed [VEL_W-1:0]   VelBird;
  logic                      q_I;
  logic                      q_Flap;
  logic                      q_UnPress;
  logic                      q_Grav;
  logic                      q_Lost;

  modport master (
    output SCEN, Start, Ack, Flap_Button, Hit,
    input  XBird, YBird, VelBird, q_I, q_Flap, q_UnPress, q_Grav, q_Lost
  );

  modport slave (
    input  SCEN, Start, Ack, Flap_Button, Hit,
    output XBird, YBird, VelBird, q_I, q_Flap, q_UnPress, q_Grav, q_Lost
  );
endinterface

// File: rtl/flappy_vel_integrator.sv
// Y/velocity registers with saturating gravity and floor/ceiling detection.
module flappy_vel_integrator
  import flappy_pkg::*;
#(
  parameter int unsigned COORD_W  = COORD_W_DEF,
  parameter int unsigned VEL_W    = VEL_W_DEF,
  parameter int unsigned Y_START  = Y_START_DEF,
  parameter int unsigned Y_CEIL   = Y_CEIL_DEF,
  parameter int unsigned Y_FLOOR  = Y_FLOOR_DEF,
  parameter int unsigned FLAP_VEL = 6,
  parameter int unsigned GRAV     = 1,
  parameter int unsigned VMAX     = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    scen_i,
  input  phys_op_e                op_i,
  output logic [COORD_W-1:0]      y_o,
  output logic signed [VEL_W-1:0] vel_o,
  output logic                    floor_c_o,
  output logic                    ceil_c_o
);

  localparam int unsigned YW = COORD_W + 2;
  localparam logic [COORD_W-1:0]      Y_INIT   = COORD_W'(Y_START);
  localparam logic [COORD_W-1:0]      Y_TOP    = COORD_W'(Y_CEIL);
  localparam logic [COORD_W-1:0]      Y_BOT    = COORD_W'(Y_FLOOR);
  localparam logic signed [VEL_W-1:0] FLAP_NEG = VEL_W'(-int'(FLAP_VEL));
  localparam logic signed [VEL_W:0]   VMAX_W   = (VEL_W+1)'(VMAX);
  localparam logic signed [VEL_W:0]   GRAV_W   = (VEL_W+1)'(GRAV);

  logic [COORD_W-1:0]      y_q, y_d;
  logic signed [VEL_W-1:0] vel_q, vel_d;
  logic signed [YW-1:0]    y_next_c;
  logic signed [VEL_W:0]   vel_sum_c;
  logic signed [VEL_W-1:0] vel_sat_c;
  logic [COORD_W-1:0]      y_clamp_c;
  logic                    clamped_c;

  // Wide position step, limit compares and saturating gravity
  always_comb begin
    y_next_c  = $signed({2'b00, y_q}) + YW'(vel_q);
    floor_c_o = (y_next_c >= $signed(YW'(Y_FLOOR)));
    ceil_c_o  = (y_next_c <  $signed(YW'(Y_CEIL)));
    vel_sum_c = (VEL_W+1)'(vel_q) + GRAV_W;
    vel_sat_c = (vel_sum_c > VMAX_W) ? VEL_W'(VMAX) : vel_sum_c[VEL_W-1:0];
    clamped_c = floor_c_o | ceil_c_o;
    if (floor_c_o)     y_clamp_c = Y_BOT;
    else if (ceil_c_o) y_clamp_c = Y_TOP;
    else               y_clamp_c = y_next_c[COORD_W-1:0];
  end

  // Next position/velocity for the requested operation
  always_comb begin
    y_d   = y_q;
    vel_d = vel_q;
    if (scen_i) begin
      case (op_i)
        OP_INIT: begin
          y_d   = Y_INIT;
          vel_d = '0;
        end
        OP_LAUNCH: begin
          y_d   = Y_INIT;
          vel_d = FLAP_NEG;
        end
        OP_FLAP: begin
          y_d   = y_clamp_c;
          vel_d = clamped_c ? '0 : FLAP_NEG;
        end
        OP_GRAV: begin
          y_d   = y_clamp_c;
          vel_d = clamped_c ? '0 : vel_sat_c;
        end
        default: ;
      endcase
    end
  end

  // Position and velocity registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      y_q   <= Y_INIT;
      vel_q <= '0;
    end else begin
      y_q   <= y_d;
      vel_q <= vel_d;
    end
  end

  assign y_o   = y_q;
  assign vel_o = vel_q;

endmodule

// File: rtl/flappy_bird_physics.sv
// Bird vertical physics: flap/gravity FSM and flap counter.
// Optional FLAPPY_CEIL_KILL_EN: touching the ceiling also loses the game.
module flappy_bird_physics
  import flappy_pkg::*;
#(
  parameter int unsigned COORD_W    = COORD_W_DEF,
  parameter int unsigned VEL_W      = VEL_W_DEF,
  parameter int unsigned X_START    = X_START_DEF,
  parameter int unsigned Y_START    = Y_START_DEF,
  parameter int unsigned Y_CEIL     = Y_CEIL_DEF,
  parameter int unsigned Y_FLOOR    = Y_FLOOR_DEF,
  parameter int unsigned FLAP_VEL   = 6,
  parameter int unsigned FLAP_TICKS = 4,
  parameter int unsigned GRAV       = 1,
  parameter int unsigned VMAX       = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  flappy_bird_physics_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(FLAP_TICKS + 1);

  logic [4:0]              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [COORD_W-1:0]      x_q, y_q;
  logic signed [VEL_W-1:0] vel_q;
  phys_op_e                op_c;
  logic                    floor_c, ceil_c, lose_c, flap_done_c;

  flappy_vel_integrator #(
    .COORD_W (COORD_W),
    .VEL_W   (VEL_W),
    .Y_START (Y_START),
    .Y_CEIL  (Y_CEIL),
    .Y_FLOOR (Y_FLOOR),
    .FLAP_VEL(FLAP_VEL),
    .GRAV    (GRAV),
    .VMAX    (VMAX)
  ) u_integ (
    .clk_i    (Clk),
    .reset_i  (Reset),
    .scen_i   (bus.SCEN),
    .op_i     (op_c),
    .y_o      (y_q),
    .vel_o    (vel_q),
    .floor_c_o(floor_c),
    .ceil_c_o (ceil_c)
  );

  // Loss condition in the active play states
  always_comb begin
`ifdef FLAPPY_CEIL_KILL_EN
    lose_c = bus.Hit | floor_c | ceil_c;
`else
    lose_c = bus.Hit | floor_c;
`endif
    flap_done_c = (cnt_q == CNT_W'(FLAP_TICKS - 1));
  end

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= ST_I;
    else       state_q <= state_d;
  end

  // Next-state logic, advanced only on physics ticks
  always_comb begin
    state_d = state_q;
    if (bus.SCEN) begin
      case (state_q)
        ST_I:       if (bus.Start) state_d = ST_FLAP;
        ST_FLAP:    if (lose_c) state_d = ST_LOST;
                    else if (flap_done_c) state_d = ST_UNPRESS;
        ST_UNPRESS: if (lose_c) state_d = ST_LOST;
                    else if (!bus.Flap_Button) state_d = ST_GRAV;
        ST_GRAV:    if (lose_c) state_d = ST_LOST;
                    else if (bus.Flap_Button) state_d = ST_FLAP;
        ST_LOST:    if (bus.Ack) state_d = ST_I;
        default:    state_d = ST_I;
      endcase
    end
  end

  // Integrator operation and flap counter update per state
  always_comb begin
    op_c  = OP_HOLD;
    cnt_d = cnt_q;
    if (bus.SCEN) begin
      cnt_d = '0;
      case (state_q)
        ST_I:       op_c = bus.Start ? OP_LAUNCH : OP_INIT;
        ST_FLAP:    op_c = OP_FLAP;
        ST_UNPRESS: op_c = OP_GRAV;
        ST_GRAV:    op_c = bus.Flap_Button ? OP_FLAP : OP_GRAV;
        default:    op_c = OP_HOLD;
      endcase
      if (state_q == ST_FLAP && state_d == ST_FLAP) cnt_d = CNT_W'(cnt_q + 1'b1);
    end
  end

  // Flap counter and fixed X register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= '0;
      x_q   <= COORD_W'(X_START);
    end else begin
      cnt_q <= cnt_d;
      x_q   <= x_q;
    end
  end

  assign bus.XBird     = x_q;
  assign bus.YBird     = y_q;
  assign bus.VelBird   = vel_q;
  assign bus.q_I       = state_q[S_I];
  assign bus.q_Flap    = state_q[S_FLAP];
  assign bus.q_UnPress = state_q[S_UNPRESS];
  assign bus.q_Grav    = state_q[S_GRAV];
  assign bus.q_Lost    = state_q[S_LOST];

endmodule

// File: tb/tb_flappy_bird_physics.sv
// Directed self-checking bench for flappy_bird_physics.
module tb_flappy_bird_physics;

  localparam logic [4:0] E_I = 5'b10000;
  localparam logic [4:0] E_F = 5'b01000;
  localparam logic [4:0] E_U = 5'b00100;
  localparam logic [4:0] E_G = 5'b00010;
  localparam logic [4:0] E_L = 5'b00001;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  flappy_bird_physics_if #(.COORD_W(10), .VEL_W(5)) bus ();

  flappy_bird_physics dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input logic [4:0] st, input int y, input int v);
    logic [4:0] s;
    s = {bus.q_I, bus.q_Flap, bus.q_UnPress, bus.q_Grav, bus.q_Lost};
    chk({tag, " state"}, 32'(s), 32'(st));
    chk({tag, " Y"}, 32'(bus.YBird), y);
    chk({tag, " vel"}, 32'(bus.VelBird), v);
  endtask

  task automatic tick(input logic st, input logic ak, input logic bt, input logic ht);
    bus.Start = st; bus.Ack = ak; bus.Flap_Button = bt; bus.Hit = ht;
    bus.SCEN = 1'b1;
    @(posedge clk); #1;
    bus.SCEN = 1'b0; bus.Start = 1'b0; bus.Ack = 1'b0; bus.Hit = 1'b0;
  endtask

  task automatic idle(input logic st, input logic ak, input logic bt, input logic ht);
    bus.Start = st; bus.Ack = ak; bus.Flap_Button = bt; bus.Hit = ht;
    bus.SCEN = 1'b0;
    @(posedge clk); #1;
    bus.Start = 1'b0; bus.Ack = 1'b0; bus.Hit = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.SCEN = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int exp_y [13];
    exp_y = '{205, 201, 198, 196, 195, 195, 196, 198, 201, 205, 210, 216, 223};
    bus.SCEN = 0; bus.Start = 0; bus.Ack = 0; bus.Flap_Button = 0; bus.Hit = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    do_reset();
    chk_all("reset", E_I, 240, 0);
    chk("reset X", 32'(bus.XBird), 144);

    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 0);
      chk_all("idle", E_I, 240, 0);
    end
    tick(0, 1, 0, 1);
    chk_all("ack/hit in I", E_I, 240, 0);
    idle(1, 0, 0, 0);
    chk_all("start no scen", E_I, 240, 0);

    tick(1, 0, 0, 0);
    chk_all("launch", E_F, 240, -6);
    tick(0, 1, 0, 0);
    chk_all("flap1", E_F, 234, -6);
    tick(0, 0, 0, 0);
    chk_all("flap2", E_F, 228, -6);
    tick(0, 0, 0, 0);
    chk_all("flap3", E_F, 222, -6);
    tick(0, 0, 0, 0);
    chk_all("flap4", E_U, 216, -6);

    tick(0, 0, 0, 0);
    chk_all("unpress rel", E_G, 210, -5);
    for (int i = 0; i < 13; i++) begin
      tick(0, 0, 0, 0);
      chk_all("grav", E_G, exp_y[i], -4 + i);
    end
    tick(0, 0, 0, 0);
    chk_all("vmax sat", E_G, 231, 8);
    for (int k = 1; k <= 29; k++) begin
      tick(0, 0, 0, 0);
      chk_all("fall", E_G, 231 + 8 * k, 8);
    end
    tick(0, 0, 1, 0);
    chk_all("floor", E_L, 464, 0);
    tick(1, 0, 1, 1);
    chk_all("lost frozen", E_L, 464, 0);
    idle(0, 1, 0, 0);
    chk_all("ack no scen", E_L, 464, 0);
    tick(0, 1, 0, 0);
    chk("ack to I", 32'(bus.q_I), 1);
    tick(0, 0, 0, 0);
    chk_all("I reload", E_I, 240, 0);

    tick(1, 0, 1, 0);
    chk_all("ceil launch", E_F, 240, -6);
    for (int c = 0; c < 6; c++) begin
      for (int j = 0; j < 4; j++) tick(0, 0, 1, 0);
      chk("cycle unpress", 32'({bus.q_UnPress}), 1);
      tick(0, 0, 0, 0);
      tick(0, 0, 1, 0);
      chk_all("cycle reflap", E_F, 205 - 35 * c, -6);
    end
    for (int j = 0; j < 4; j++) tick(0, 0, 1, 0);
    chk_all("near ceil", E_U, 6, -6);
    tick(0, 0, 0, 0);
    chk_all("at ceil", E_G, 0, -5);
    tick(0, 0, 1, 0);
`ifdef FLAPPY_CEIL_KILL_EN
    chk_all("ceil clamp", E_L, 0, 0);
`else
    chk_all("ceil clamp", E_F, 0, 0);
`endif

    do_reset();
    chk_all("reset2", E_I, 240, 0);
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk_all("hit pre", E_F, 234, -6);
    idle(0, 0, 0, 1);
    chk_all("hit no scen", E_F, 234, -6);
    tick(0, 0, 0, 1);
    chk_all("hit", E_L, 228, -6);
    tick(1, 0, 1, 1);
    chk_all("hit frozen", E_L, 228, -6);
    do_reset();
    chk_all("reset in lost", E_I, 240, 0);

    tick(1, 0, 1, 0);
    for (int j = 0; j < 4; j++) tick(0, 0, 1, 0);
    chk_all("hold unpress", E_U, 216, -6);
    tick(0, 0, 1, 0);
    chk_all("hold no reflap1", E_U, 210, -5);
    tick(0, 0, 1, 0);
    chk_all("hold no reflap2", E_U, 205, -4);
    tick(0, 0, 0, 0);
    chk_all("release grav", E_G, 201, -3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
